cpu_core_p: RTL

//  Parametrised next-generation Hack-style CPU core with a DATA_W datapath and a registered page

---
 rtl/cpu_core_p.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_core_p.sv
// cpu_core_p: Hack-style CPU core with page register and MUL/DIV offload; MULDIV_TIMEOUT_EN adds an MD_WAIT watchdog.
// Latency: 1 cycle per instruction, MUL/DIV = unit latency + 2; stall freezes architectural state.
module cpu_core_p #(
    parameter int DATA_W      = 16,
    parameter int PAGE_W      = 14,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           instruction,
    input  logic [DATA_W-1:0]     inM,
    output logic [DATA_W-1:0]     outM,
    output logic                  writeM,
    output logic [PAGE_W-1:0]     addressMH,
    output logic [DATA_W-1:0]     addressML,
    output logic [DATA_W-1:0]     pc,
    output logic [3:0]            flags,
    input  logic                  stall,
    output logic                  alu_valid,
    output logic [DATA_W-1:0]     alu_x,
    output logic [DATA_W-1:0]     alu_y,
    output logic [5:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [3:0]            alu_flags,
    output logic                  md_start,
    output logic [1:0]            md_op,
    output logic [DATA_W-1:0]     md_a,
    output logic [DATA_W-1:0]     md_b,
    input  logic                  md_done,
    input  logic [2*DATA_W-1:0]   md_product,
    input  logic [DATA_W-1:0]     md_quot,
    input  logic [DATA_W-1:0]     md_rem
);

    typedef enum logic [1:0] {S_EXEC, S_MD_WAIT, S_MD_COMMIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_pc, r_a, r_d, r_md_a, r_md_b, r_res;
    logic [DATA_W-1:0]   w_pc_nxt, w_a_nxt, w_d_nxt, w_md_a_nxt, w_md_b_nxt, w_res_nxt;
    logic [3:0]          r_flags, r_res_flags, w_flags_nxt, w_res_flags_nxt;
    logic [PAGE_W-1:0]   r_page, w_page_nxt;
    logic [1:0]          r_md_op, w_md_op_nxt, w_dec_op;

    logic                w_is_a, w_is_p, w_is_c, w_is_md;
    logic                w_commit, w_md_start, w_alu_valid, w_jump, w_md_v, w_start_o;
    logic [DATA_W-1:0]   w_cval, w_md_r, w_pc_inc;
    logic [3:0]          w_cflags, w_md_flags;

`ifdef MULDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    r_cnt;
`endif

    assign w_is_a   = ~instruction[15];
    assign w_is_p   = instruction[15] & instruction[14];
    assign w_is_c   = instruction[15] & ~instruction[14];
    assign w_pc_inc = r_pc + DATA_W'(1);

    always_comb begin
        w_is_md  = w_is_c;
        w_dec_op = 2'b00;
        case (instruction[11:6])
            6'b010100: w_dec_op = 2'b00;
            6'b010101: w_dec_op = 2'b01;
            6'b010110: w_dec_op = 2'b10;
            default:   w_is_md  = 1'b0;
        endcase
    end

    // Divide overflow is reported for a zero divisor, multiply overflow when the high half is not a sign extension.
    always_comb begin
        w_md_r = md_quot;
        w_md_v = (r_md_b == '0);
        case (r_md_op)
            2'b00: begin
                w_md_r = md_product[DATA_W-1:0];
                w_md_v = (md_product[2*DATA_W-1:DATA_W] != {DATA_W{md_product[DATA_W-1]}});
            end
            2'b10:   w_md_r = md_rem;
            default: w_md_r = md_quot;
        endcase
    end

    assign w_md_flags = {1'b0, w_md_r[DATA_W-1], (w_md_r == '0), w_md_v};

    always_comb begin
        w_cval   = alu_result;
        w_cflags = alu_flags;
        if (r_state == S_MD_COMMIT) begin
            w_cval   = r_res;
            w_cflags = r_res_flags;
        end
    end

    assign w_jump = (instruction[2] & w_cflags[2]) |
                    (instruction[1] & w_cflags[1]) |
                    (instruction[0] & ~w_cflags[2] & ~w_cflags[1]);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_a_nxt         = r_a;
        w_d_nxt         = r_d;
        w_flags_nxt     = r_flags;
        w_page_nxt      = r_page;
        w_md_op_nxt     = r_md_op;
        w_md_a_nxt      = r_md_a;
        w_md_b_nxt      = r_md_b;
        w_res_nxt       = r_res;
        w_res_flags_nxt = r_res_flags;
        w_commit        = 1'b0;
        w_md_start      = 1'b0;
        w_alu_valid     = 1'b0;
        case (r_state)
            S_EXEC: begin
                if (!stall) begin
                    if (w_is_a) begin
                        w_a_nxt  = DATA_W'(instruction[14:0]);
                        w_pc_nxt = w_pc_inc;
                    end else if (w_is_p) begin
                        w_page_nxt = PAGE_W'(instruction[13:0]);
                        w_pc_nxt   = w_pc_inc;
                    end else if (w_is_md) begin
                        w_md_start  = 1'b1;
                        w_md_op_nxt = w_dec_op;
                        w_md_a_nxt  = r_d;
                        w_md_b_nxt  = r_a;
                        w_state_nxt = S_MD_WAIT;
                    end else begin
                        w_alu_valid = 1'b1;
                        w_commit    = 1'b1;
                    end
                end
            end
            // md_done is taken even under stall; the commit itself waits for !stall.
            S_MD_WAIT: begin
                if (md_done) begin
                    w_res_nxt       = w_md_r;
                    w_res_flags_nxt = w_md_flags;
                    w_state_nxt     = S_MD_COMMIT;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_res_nxt       = '0;
                    w_res_flags_nxt = 4'b0011;
                    w_state_nxt     = S_MD_COMMIT;
                end
`endif
            end
            S_MD_COMMIT: begin
                if (!stall) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            default: w_state_nxt = S_EXEC;
        endcase
        // Jump target and M address both use the A value from before this commit.
        if (w_commit) begin
            if (instruction[5]) w_a_nxt = w_cval;
            if (instruction[4]) w_d_nxt = w_cval;
            w_flags_nxt = w_cflags;
            w_pc_nxt    = w_jump ? r_a : w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EXEC;
            r_pc        <= '0;
            r_a         <= '0;
            r_d         <= '0;
            r_flags     <= '0;
            r_page      <= '0;
            r_md_op     <= '0;
            r_md_a      <= '0;
            r_md_b      <= '0;
            r_res       <= '0;
            r_res_flags <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_a         <= w_a_nxt;
            r_d         <= w_d_nxt;
            r_flags     <= w_flags_nxt;
            r_page      <= w_page_nxt;
            r_md_op     <= w_md_op_nxt;
            r_md_a      <= w_md_a_nxt;
            r_md_b      <= w_md_b_nxt;
            r_res       <= w_res_nxt;
            r_res_flags <= w_res_flags_nxt;
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_MD_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`endif

    // Operands are shown live during the start pulse and from the registered copy afterwards.
    assign w_start_o = rst_n & w_md_start;
    assign md_start  = w_start_o;
    assign md_op     = w_start_o ? w_dec_op : r_md_op;
    assign md_a      = w_start_o ? r_d : r_md_a;
    assign md_b      = w_start_o ? r_a : r_md_b;

    assign outM      = w_cval;
    assign writeM    = rst_n & w_commit & instruction[3];
    assign addressMH = r_page;
    assign addressML = r_a;
    assign pc        = r_pc;
    assign flags     = r_flags;
    assign alu_valid = rst_n & w_alu_valid;
    assign alu_x     = r_d;
    assign alu_y     = instruction[12] ? inM : r_a;
    assign alu_op    = instruction[11:6];

endmodule
